// File: rtl/mem_burst_ctrl.sv
// Burst request sequencer for the 32-entry register memory: write beats pass straight through, read beats land in a back-pressurable output register.
// Optional MEM_BURST_CTRL_WRAP_EN: burst addresses wrap modulo MEM_SIZE instead of rejecting out-of-range requests.
module mem_burst_ctrl #(
  parameter  int WIDTH      = 32,
  parameter  int MEM_SIZE   = 32,
  localparam int ADDR_WIDTH = $clog2(MEM_SIZE)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_we,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic [ADDR_WIDTH-1:0] req_len,
  input  logic                  wdata_valid,
  output logic                  wdata_ready,
  input  logic [WIDTH-1:0]      wdata,
  output logic                  rdata_valid,
  input  logic                  rdata_ready,
  output logic [WIDTH-1:0]      rdata,
  output logic                  rdata_last,
  output logic                  busy,
  output logic                  err,
  output logic                  mem_write,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [WIDTH-1:0]      mem_idata,
  input  logic [WIDTH-1:0]      mem_odata
);

  typedef enum logic [1:0] {
    IDLE,
    WR,
    RD
  } state_t;

  state_t                state_q, state_d;
  logic [ADDR_WIDTH-1:0] cur_addr_q, cur_addr_d;
  logic [ADDR_WIDTH-1:0] beats_left_q, beats_left_d;
  logic [WIDTH-1:0]      rdata_q, rdata_d;
  logic                  rdata_valid_q, rdata_valid_d;
  logic                  rdata_last_q, rdata_last_d;
  logic                  err_q, err_d;
  logic                  range_err;

`ifdef MEM_BURST_CTRL_WRAP_EN
  assign range_err = 1'b0;
`else
  localparam logic [ADDR_WIDTH:0] LAST_ADDR = (ADDR_WIDTH + 1)'(MEM_SIZE - 1);
  logic [ADDR_WIDTH:0] req_end;

  // One extra bit so the end address cannot silently wrap before the compare.
  assign req_end   = {1'b0, req_addr} + {1'b0, req_len};
  assign range_err = (req_end > LAST_ADDR);
`endif

  always_comb begin
    state_d       = state_q;
    cur_addr_d    = cur_addr_q;
    beats_left_d  = beats_left_q;
    rdata_d       = rdata_q;
    rdata_valid_d = rdata_valid_q;
    rdata_last_d  = rdata_last_q;
    err_d         = 1'b0;

    if (rdata_valid_q && rdata_ready) begin
      rdata_valid_d = 1'b0;
    end

    case (state_q)
      IDLE: begin
        if (req_valid) begin
          cur_addr_d   = req_addr;
          beats_left_d = req_len;
          if (range_err) begin
            err_d = 1'b1;
          end else begin
            state_d = req_we ? WR : RD;
          end
        end
      end
      WR: begin
        if (wdata_valid) begin
          cur_addr_d   = cur_addr_q + 1'b1;
          beats_left_d = beats_left_q - 1'b1;
          if (beats_left_q == '0) begin
            state_d = IDLE;
          end
        end
      end
      RD: begin
        // A capture may refill the register in the same cycle the consumer drains it.
        if (!rdata_valid_q || rdata_ready) begin
          rdata_d       = mem_odata;
          rdata_valid_d = 1'b1;
          rdata_last_d  = (beats_left_q == '0);
          cur_addr_d    = cur_addr_q + 1'b1;
          beats_left_d  = beats_left_q - 1'b1;
          if (beats_left_q == '0) begin
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= IDLE;
      cur_addr_q    <= '0;
      beats_left_q  <= '0;
      rdata_q       <= '0;
      rdata_valid_q <= 1'b0;
      rdata_last_q  <= 1'b0;
      err_q         <= 1'b0;
    end else begin
      state_q       <= state_d;
      cur_addr_q    <= cur_addr_d;
      beats_left_q  <= beats_left_d;
      rdata_q       <= rdata_d;
      rdata_valid_q <= rdata_valid_d;
      rdata_last_q  <= rdata_last_d;
      err_q         <= err_d;
    end
  end

  assign req_ready   = (state_q == IDLE);
  assign busy        = (state_q != IDLE);
  assign wdata_ready = (state_q == WR);
  assign mem_write   = (state_q == WR) && wdata_valid;
  assign mem_addr    = cur_addr_q;
  assign mem_idata   = wdata;
  assign rdata       = rdata_q;
  assign rdata_valid = rdata_valid_q;
  assign rdata_last  = rdata_last_q;
  assign err         = err_q;

endmodule
